// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master (sequencing controller) drives start/a/b; the slave (subtractor)
// returns busy/done and the held result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b (mod 2^WIDTH) plus unsigned borrow-out,
// processed LSB first through a single full-subtractor cell, one bit per clock.
// IDLE accepts start and latches the operands, SHIFT runs WIDTH bit steps,
// DONE presents a one-cycle done pulse before returning to IDLE.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             bit_x;
  logic             bit_y;
  logic             bit_d;
  logic             bit_br;

  // Single full-subtractor cell working on the current LSBs and stored borrow
  always_comb begin
    bit_x  = a_sh_q[0];
    bit_y  = b_sh_q[0];
    bit_d  = bit_x ^ bit_y ^ borrow_q;
    bit_br = (~bit_x & bit_y) | (~bit_x & borrow_q) | (bit_y & borrow_q);
  end

  // Next-state and datapath updates; everything holds unless the state acts
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        // Operands are only captured here, so later changes on a/b are harmless
        if (bus.start) begin
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = {bit_d, res_sh_q[WIDTH-1:1]};
        borrow_d = bit_br;
        cnt_d    = cnt_q + 1'b1;
        // On the last bit the freshly completed result goes straight to the
        // output registers so diff/bout are valid together with done
        if (cnt_q == LAST_BIT) begin
          diff_d  = {bit_d, res_sh_q[WIDTH-1:1]};
          bout_d  = bit_br;
          state_d = DONE;
        end
      end

      DONE: begin
        // start is deliberately ignored here; a new request needs IDLE
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed plus randomized bench for serial_subtractor. Expected results come
// from plain modular arithmetic on the operands; timing expectations come from
// the documented handshake (busy for WIDTH cycles, one-cycle done pulse).
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Result the DUT is expected to be holding from its last completion
  logic [W-1:0] prev_diff = '0;
  logic         prev_bout = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation starting from IDLE. repulse[k] re-asserts start (with
  // a=b=1) during busy cycle k; poke_done asserts start with junk operands in
  // the DONE cycle. Returns in the first IDLE cycle after DONE.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [63:0] repulse, input bit poke_done,
                       input string tag);
    int unsigned  ea, eb;
    logic [W-1:0] exp_d;
    logic         exp_b;
    int           busy_cycles;
    int           k;
    bit           hold_bad;

    ea    = ia;
    eb    = ib;
    exp_d = W'((ea + (1 << W) - eb) % (1 << W));
    exp_b = (ea < eb);

    bus.a     = ia;
    bus.b     = ib;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, "/accept_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, "/accept_done"}, 32'(bus.done), 32'd0);

    busy_cycles = 0;
    hold_bad    = 1'b0;
    k           = 0;
    while (!bus.done && k < 4 * W) begin
      k++;
      if (bus.busy) busy_cycles++;
      if (bus.diff !== prev_diff || bus.bout !== prev_bout) hold_bad = 1'b1;
      if (repulse[k]) begin
        bus.start = 1'b1;
        bus.a     = W'(1);
        bus.b     = W'(1);
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;

    chk({tag, "/done_seen"},   32'(bus.done),  32'd1);
    chk({tag, "/busy_cycles"}, 32'(busy_cycles), 32'(W));
    chk({tag, "/hold_during"}, 32'(hold_bad),  32'd0);
    chk({tag, "/diff"},        32'(bus.diff),  32'(exp_d));
    chk({tag, "/bout"},        32'(bus.bout),  32'(exp_b));

    if (poke_done) begin
      bus.start = 1'b1;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
    end
    tick();
    bus.start = 1'b0;
    chk({tag, "/done_pulse_end"}, 32'(bus.done), 32'd0);
    chk({tag, "/idle_busy"},      32'(bus.busy), 32'd0);
    chk({tag, "/diff_held"},      32'(bus.diff), 32'(exp_d));
    chk({tag, "/bout_held"},      32'(bus.bout), 32'(exp_b));

    prev_diff = exp_d;
    prev_bout = exp_b;
    $display("[TB] op %s a=%0d b=%0d diff=%0h bout=%0d", tag, ia, ib, bus.diff, bus.bout);
  endtask

  initial begin
    int done_cnt;

    // 1. Reset with start held high: must come up idle with cleared outputs
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.a     = W'(100);
    bus.b     = W'(37);
    tick();
    tick();
    chk("reset/busy", 32'(bus.busy), 32'd0);
    chk("reset/done", 32'(bus.done), 32'd0);
    chk("reset/diff", 32'(bus.diff), 32'd0);
    chk("reset/bout", 32'(bus.bout), 32'd0);
    rst_n     = 1'b1;
    bus.start = 1'b0;
    tick();
    chk("reset/no_accept", 32'(bus.busy), 32'd0);
    $display("[TB] reset released");

    // 2./3. Directed operands
    do_op(W'(100),   W'(37),    64'h0, 1'b0, "100-37");
    do_op(W'(5),     W'(9),     64'h0, 1'b0, "5-9");
    do_op(W'('h00),  W'('hFF),  64'h0, 1'b1, "00-FF");
    do_op(W'('hA5),  W'('hA5),  64'h0, 1'b0, "A5-A5");

    // 4. start re-pulsed with a=b=1 on busy cycles 3 and 8, then immediate restart
    do_op(W'(200),   W'(37),    64'h108, 1'b0, "200-37_repulse");
    do_op(W'(17),    W'(200),   64'h0, 1'b0, "first_idle_start");

    // 5. Reset in the fourth SHIFT cycle aborts with no done pulse
    bus.a     = W'(50);
    bus.b     = W'(20);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("abort/busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("abort/busy", 32'(bus.busy), 32'd0);
    chk("abort/done", 32'(bus.done), 32'd0);
    chk("abort/diff", 32'(bus.diff), 32'd0);
    chk("abort/bout", 32'(bus.bout), 32'd0);
    rst_n     = 1'b1;
    prev_diff = '0;
    prev_bout = 1'b0;
    done_cnt  = 0;
    for (int i = 0; i < 2 * W; i++) begin
      tick();
      if (bus.done) done_cnt++;
    end
    chk("abort/no_done", 32'(done_cnt), 32'd0);
    $display("[TB] abort done_count=%0d", done_cnt);
    do_op(W'(10), W'(3), 64'h0, 1'b0, "10-3_after_abort");

    // 6. Random back-to-back operations
    for (int i = 0; i < 1000; i++) begin
      do_op(W'($urandom), W'($urandom), 64'h0, bit'(i % 2), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
